instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential program loader that encodes instruction requests into 32-bit MIPS machine words for the single-cycle CPU's controller. It accepts one instruction request per cycle over a valid/ready handshake and emits the packed word with a registered instruction-memory write. It writes to consecutive word addresses and reports completion, capacity exhaustion and illegal requests. It sits between the testbench/boot source and instruction memory, ahead of the CPU.

## Interface
- IMEM_AW, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address written after reset or start; must be < 2^IMEM_AW
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  restart load at BASE_ADDR; clears done, full, count, err
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept
- in_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 ORI, 7 LW, 8 SW, 9 BEQ, 10 J, 11–15 illegal
- in_rs / in_rt / in_rd  in  5 each  register fields
- in_imm  in  16  immediate for I-type kinds
- in_target  in  26  jump target for J
- in_last  in  1  final instruction of the program
- imem_we  out  1  write strobe, one cycle per word
- imem_addr  out  IMEM_AW  word address of the current write
- imem_wdata  out  32  encoded word
- done  out  1  level; program complete
- full  out  1  level; capacity exhausted
- err  out  1  sticky; an illegal kind was consumed
- count  out  IMEM_AW+1  words written since reset/start

## Operation
- Accept = in_valid && in_ready at a rising edge.
- in_ready = !rst && !done && !full && !start.
- R-type kinds (0–4):
  - op 000000, rs, rt, rd, shamt 0.
  - func: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
- I-type kinds: op | rs | rt | imm[15:0], imm passed unmodified.
  - ADDI 001000, ORI 001101, LW 100011, SW 101011, BEQ 000100.
- J: op 000010 | target[25:0].
- Fields unused by a kind are ignored; in_rd is ignored for I-type.
- Legal accept: word written at the next address, then address and count increment.
- Illegal accept:
  - Request consumed and err set.
  - No write; address and count unchanged.
- in_last on any accept, legal or illegal: done set after that request; in_ready drops the next cycle.
- Capacity = 2^IMEM_AW − BASE_ADDR. full sets after the capacity-th legal accept, so in_ready drops the next cycle and the address never wraps.
- in_last together with the final capacity word sets both done and full.
- start:
  - Returns the address to BASE_ADDR and clears count, done, full and err.
  - Any request presented in the same cycle is not accepted.
  - A write already registered still completes that cycle.
- States: LOAD (accepting), DONE, FULL. DONE or FULL exits only on start or rst; start has priority over all events.

## Timing
- Latency 1: accept at edge N gives imem_we=1 with word and address during cycle N+1.
- Throughput is one word per cycle while in_valid stays high.
- imem_we, imem_addr and imem_wdata are registered. imem_wdata holds its last value when imem_we=0.
- count and done update at the same edge that raises imem_we for the corresponding word.
- Reset values: in_ready 0 while rst is high, 1 the cycle after; imem_we 0; imem_addr BASE_ADDR; imem_wdata 0; done 0; full 0; err 0; count 0.
- rst mid-load discards any pending write; imem_we is 0 the cycle after rst.

## Structure
- Shared package instr_pkg:
  - Opcode and func constants.
  - in_kind enum.
  - ALU control codes, so the decode side and this encoder agree.
- Sub-module instr_word_pack: combinational fields-to-word packer with a legal flag. It is reusable by a future assembler test bench.
- Top level holds the handshake, output register, address/count counters and the LOAD/DONE/FULL state.

## Test plan
- ADD rs=1 rt=2 rd=3 after reset → cycle+1: imem_we=1, addr 0x00, wdata 0x00221820, count 1.
- Back-to-back stream:
  - Requests: ADDI rt=8 imm=5; ORI rt=1 imm=0x00FF; LW rs=29 rt=9 imm=0xFFFC; BEQ rs=1 rt=2 imm=0xFFFF; J target=0x10 with in_last.
  - Words: 0x20080005, 0x340100FF, 0x8FA9FFFC, 0x1022FFFF, 0x08000010 at addrs 0–4.
  - done=1 and in_ready=0 after the fifth write.
- kind=12 between two legal ADDs → err=1, no write, addresses 0 and 1 contiguous, count 2.
- IMEM_AW=2, BASE_ADDR=1, four valid requests → three writes (addrs 1–3), full=1, fourth request not accepted.
- start asserted with in_valid in DONE → no accept that cycle; next accept writes at BASE_ADDR with count 1 and err cleared.
- rst asserted in the cycle after an accept → no imem_we; all outputs at reset values.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared MIPS encoding constants: opcodes, R-type func codes, request kinds
// and ALU control codes, so the decode side and the encoder agree.
package instr_pkg;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_ADDI = 4'd5,
    K_ORI  = 4'd6,
    K_LW   = 4'd7,
    K_SW   = 4'd8,
    K_BEQ  = 4'd9,
    K_J    = 4'd10
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_DONE = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // R-type func field to the ALU operation the CPU's ALU decoder selects.
  function automatic alu_ctrl_e func_to_alu(input logic [5:0] fn);
    alu_ctrl_e a;
    case (fn)
      FN_SUB:  a = ALU_SUB;
      FN_AND:  a = ALU_AND;
      FN_OR:   a = ALU_OR;
      FN_SLT:  a = ALU_SLT;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: request fields to a 32-bit MIPS word plus a legal flag.
module instr_word_pack
  import instr_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  kind_e k;
  assign k = kind_e'(kind);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (k)
      K_ADD:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      K_SUB:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      K_AND:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      K_OR:   word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      K_SLT:  word = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      K_ADDI: word = {OP_ADDI, rs, rt, imm};
      K_ORI:  word = {OP_ORI, rs, rt, imm};
      K_LW:   word = {OP_LW, rs, rt, imm};
      K_SW:   word = {OP_SW, rs, rt, imm};
      K_BEQ:  word = {OP_BEQ, rs, rt, imm};
      K_J:    word = {OP_J, target};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential program loader: accepts instruction requests, encodes them and
// writes them to consecutive instruction-memory word addresses.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int IMEM_AW   = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_kind,
  input  logic [4:0]         in_rs,
  input  logic [4:0]         in_rt,
  input  logic [4:0]         in_rd,
  input  logic [15:0]        in_imm,
  input  logic [25:0]        in_target,
  input  logic               in_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               done,
  output logic               full,
  output logic               err,
  output logic [IMEM_AW:0]   count
);

  localparam logic [IMEM_AW-1:0] BASE = IMEM_AW'(BASE_ADDR);
  localparam logic [IMEM_AW:0]   CAP  = (IMEM_AW+1)'((2 ** IMEM_AW) - BASE_ADDR);

  state_e             state_q, state_d;
  logic [IMEM_AW-1:0] ptr_q, ptr_d;
  logic [IMEM_AW:0]   count_q, count_d;
  logic               done_q, done_d;
  logic               full_q, full_d;
  logic               err_q, err_d;
  logic               we_q, we_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic [31:0] pack_word;
  logic        pack_legal;
  logic        accept;

  instr_word_pack u_pack (
    .kind   (in_kind),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  assign in_ready = !rst && (state_q == ST_LOAD) && !start;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    done_d  = done_q;
    full_d  = full_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (start) begin
      state_d = ST_LOAD;
      ptr_d   = BASE;
      count_d = '0;
      done_d  = 1'b0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else if (accept) begin
      if (pack_legal) begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = pack_word;
        count_d = count_q + 1'b1;
        // Hold the pointer on the last slot so it never wraps past the top.
        if (count_d == CAP) full_d = 1'b1;
        else                ptr_d  = ptr_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
      if (in_last) done_d = 1'b1;
      if (done_d)      state_d = ST_DONE;
      else if (full_d) state_d = ST_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      ptr_q   <= BASE;
      count_q <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      done_q  <= done_d;
      full_q  <= full_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign full       = full_q;
  assign err        = err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding table, handshake corner sequences, a
// small-capacity instance and a randomized run against a reference model.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_last;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, imem_we, done, full, err;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  count;

  logic        s_in_ready, s_imem_we, s_done, s_full, s_err;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic [2:0]  s_count;

  instr_encoder #(.IMEM_AW(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .done(done), .full(full), .err(err), .count(count)
  );

  instr_encoder #(.IMEM_AW(2), .BASE_ADDR(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .in_last(in_last), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .done(s_done), .full(s_full), .err(s_err), .count(s_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        last;
    logic [31:0] word;
  } vec_t;

  vec_t tab[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic last);
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt; in_last = last;
  endtask

  task automatic idle;
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
  endtask

  // Reference encoding from the instruction-format rules, as plain arithmetic.
  function automatic logic [32:0] ref_word(input int k, input int rs, input int rt,
                                           input int rd, input int imm, input int tgt);
    int fn_of[5] = '{32, 34, 36, 37, 42};
    int op_of[5] = '{8, 13, 35, 43, 4};
    longint w;
    if (k <= 4) begin
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + fn_of[k];
      return {1'b1, w[31:0]};
    end else if (k <= 9) begin
      w = longint'(op_of[k-5]) * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + imm;
      return {1'b1, w[31:0]};
    end else if (k == 10) begin
      w = 2 * 67108864 + longint'(tgt);
      return {1'b1, w[31:0]};
    end
    return 33'd0;
  endfunction

  int          m_ptr, m_cnt;
  logic        m_done, m_full, m_err, m_acc, m_start;
  logic [32:0] m_w;
  logic [3:0]  r_kind;
  logic [4:0]  r_rs, r_rt, r_rd;
  logic [15:0] r_imm;
  logic [25:0] r_tgt;
  logic        r_last, r_valid;

  initial begin
    tab[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       1'b0, 32'h00221820};
    tab[1]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h1234, 26'h0,       1'b0, 32'h00853022};
    tab[2]  = '{4'd2,  5'd7,  5'd8,  5'd9,  16'h0000, 26'h3FFFFFF, 1'b0, 32'h00E84824};
    tab[3]  = '{4'd3,  5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,       1'b0, 32'h03FFF825};
    tab[4]  = '{4'd4,  5'd10, 5'd11, 5'd12, 16'hFFFF, 26'h155,     1'b0, 32'h014B602A};
    tab[5]  = '{4'd8,  5'd2,  5'd3,  5'd31, 16'h8000, 26'h0,       1'b0, 32'hAC438000};
    tab[6]  = '{4'd5,  5'd0,  5'd8,  5'd17, 16'h0005, 26'h0,       1'b0, 32'h20080005};
    tab[7]  = '{4'd6,  5'd0,  5'd1,  5'd0,  16'h00FF, 26'h0,       1'b0, 32'h340100FF};
    tab[8]  = '{4'd7,  5'd29, 5'd9,  5'd0,  16'hFFFC, 26'h0,       1'b0, 32'h8FA9FFFC};
    tab[9]  = '{4'd9,  5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       1'b0, 32'h1022FFFF};
    tab[10] = '{4'd10, 5'd3,  5'd4,  5'd0,  16'h0000, 26'h10,      1'b1, 32'h08000010};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_kind = '0;
    in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;

    // Reset values
    tick; tick;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", {24'd0, imem_addr}, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_flags", {29'd0, done, full, err}, 32'd0);
    chk("rst_count", {23'd0, count}, 32'd0);
    chk("rst_s_addr", {30'd0, s_imem_addr}, 32'd1);
    rst = 1'b0; #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Encoding table streamed back-to-back
    for (int i = 0; i < 11; i++) begin
      drive(tab[i].kind, tab[i].rs, tab[i].rt, tab[i].rd, tab[i].imm, tab[i].tgt, tab[i].last);
      tick;
      chk("tab_we", {31'd0, imem_we}, 32'd1);
      chk("tab_addr", {24'd0, imem_addr}, i);
      chk("tab_wdata", imem_wdata, tab[i].word);
      chk("tab_count", {23'd0, count}, i + 1);
      chk("tab_done", {31'd0, done}, (i == 10) ? 32'd1 : 32'd0);
    end
    idle; #1;
    chk("done_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("done_we_low", {31'd0, imem_we}, 32'd0);
    chk("done_wdata_hold", imem_wdata, 32'h08000010);

    // start with a request in DONE: not accepted, state cleared
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0); start = 1'b1; #1;
    chk("start_ready", {31'd0, in_ready}, 32'd0);
    tick; start = 1'b0;
    chk("start_no_we", {31'd0, imem_we}, 32'd0);
    chk("start_count", {23'd0, count}, 32'd0);
    chk("start_done", {31'd0, done}, 32'd0);

    // Illegal kind between two legal ADDs
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0); tick;
    chk("ill_a_addr", {24'd0, imem_addr}, 32'd0);
    drive(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0); tick;
    chk("ill_no_we", {31'd0, imem_we}, 32'd0);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_count", {23'd0, count}, 32'd1);
    drive(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b1); tick;
    chk("ill_b_we", {31'd0, imem_we}, 32'd1);
    chk("ill_b_addr", {24'd0, imem_addr}, 32'd1);
    chk("ill_b_count", {23'd0, count}, 32'd2);
    chk("ill_b_flags", {30'd0, done, err}, 32'd3);

    // start in DONE with err set, then a fresh write at BASE_ADDR
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0); start = 1'b1; tick; start = 1'b0;
    chk("restart_no_we", {31'd0, imem_we}, 32'd0);
    chk("restart_err", {31'd0, err}, 32'd0);
    tick;
    chk("restart_we", {31'd0, imem_we}, 32'd1);
    chk("restart_addr", {24'd0, imem_addr}, 32'd0);
    chk("restart_count", {23'd0, count}, 32'd1);
    chk("restart_err2", {31'd0, err}, 32'd0);

    // rst in the cycle after an accept
    drive(4'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0); tick;
    chk("pre_rst_addr", {24'd0, imem_addr}, 32'd1);
    rst = 1'b1; #1;
    chk("midrst_ready", {31'd0, in_ready}, 32'd0);
    tick;
    chk("midrst_we", {31'd0, imem_we}, 32'd0);
    chk("midrst_addr", {24'd0, imem_addr}, 32'd0);
    chk("midrst_wdata", imem_wdata, 32'd0);
    chk("midrst_count", {23'd0, count}, 32'd0);
    chk("midrst_flags", {29'd0, done, full, err}, 32'd0);
    rst = 1'b0;

    // Capacity on the IMEM_AW=2, BASE_ADDR=1 instance: three writes then full
    for (int i = 0; i < 4; i++) begin
      drive(4'd0, 5'(i), 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      #1;
      chk("cap_ready", {31'd0, s_in_ready}, (i < 3) ? 32'd1 : 32'd0);
      tick;
      chk("cap_we", {31'd0, s_imem_we}, (i < 3) ? 32'd1 : 32'd0);
      if (i < 3) chk("cap_addr", {30'd0, s_imem_addr}, i + 1);
      chk("cap_count", {29'd0, s_count}, (i < 3) ? i + 1 : 3);
      chk("cap_full", {31'd0, s_full}, (i >= 2) ? 32'd1 : 32'd0);
    end
    chk("cap_done", {31'd0, s_done}, 32'd0);
    idle;

    // Randomized run against the reference model
    rst = 1'b1; tick; rst = 1'b0;
    m_ptr = 0; m_cnt = 0; m_done = 0; m_full = 0; m_err = 0;
    for (int c = 0; c < 600; c++) begin
      m_start = (m_done || m_full) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 80) == 0);
      r_valid = ($urandom_range(0, 3) != 0);
      r_kind  = 4'($urandom_range(0, 15));
      r_rs = 5'($urandom()); r_rt = 5'($urandom()); r_rd = 5'($urandom());
      r_imm = 16'($urandom()); r_tgt = 26'($urandom());
      r_last = ($urandom_range(0, 59) == 0);
      in_valid = r_valid; in_kind = r_kind; in_rs = r_rs; in_rt = r_rt; in_rd = r_rd;
      in_imm = r_imm; in_target = r_tgt; in_last = r_last; start = m_start;
      #1;
      m_acc = r_valid && !m_done && !m_full && !m_start;
      chk("rnd_ready", {31'd0, in_ready}, {31'd0, !m_done && !m_full && !m_start});
      m_w = ref_word(int'(r_kind), int'(r_rs), int'(r_rt), int'(r_rd), int'(r_imm), int'(r_tgt));
      tick;
      if (m_start) begin
        m_ptr = 0; m_cnt = 0; m_done = 0; m_full = 0; m_err = 0;
        chk("rnd_we", {31'd0, imem_we}, 32'd0);
      end else if (m_acc && m_w[32]) begin
        chk("rnd_we", {31'd0, imem_we}, 32'd1);
        chk("rnd_addr", {24'd0, imem_addr}, m_ptr);
        chk("rnd_wdata", imem_wdata, m_w[31:0]);
        m_cnt++;
        if (m_cnt == 256) m_full = 1; else m_ptr++;
      end else begin
        chk("rnd_we", {31'd0, imem_we}, 32'd0);
        if (m_acc) m_err = 1;
      end
      if (m_acc && r_last) m_done = 1;
      chk("rnd_count", {23'd0, count}, m_cnt);
      chk("rnd_flags", {29'd0, done, full, err}, {29'd0, m_done, m_full, m_err});
    end
    idle;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
